user_au_chain_sequencer: RTL

- Sample-rate pacing controller placed between the audio interface stream output and the head of the LPF→HPF filter cascade.
- Admits exactly one sample per programmed sample period into the chain.
- Tracks samples in flight through the cascade by observing the cascade output handshake.
- Flags underrun, overrun, protocol and stall-timeout conditions so software can see whether the filter chain keeps up with the audio rate.

---
 rtl/user_au_chain_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/user_au_chain_sequencer.sv
// Sample-rate pacing controller: admits one sample per period into the LPF->HPF cascade
// and tracks in-flight samples. Optional statistics counters are built when AU_SEQ_STATS_EN is defined.
module user_au_chain_sequencer #(
    parameter int DataWidth     = 32,
    parameter int PeriodWidth   = 16,
    parameter int MaxInFlight   = 4,
    parameter int TimeoutCycles = 1024
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               enable_i,
    input  logic                               clear_i,
    input  logic [PeriodWidth-1:0]             period_i,
    input  logic [DataWidth-1:0]               src_data_i,
    input  logic                               src_valid_i,
    output logic                               src_ready_o,
    output logic [DataWidth-1:0]               chain_data_o,
    output logic                               chain_valid_o,
    input  logic                               chain_ready_i,
    input  logic                               ret_fire_i,
    output logic                               sample_tick_o,
    output logic [$clog2(MaxInFlight+1)-1:0]   inflight_o,
    output logic                               busy_o,
    output logic                               underrun_o,
    output logic                               overrun_o,
    output logic                               proto_err_o,
    output logic                               timeout_o,
    output logic [31:0]                        issued_count_o,
    output logic [15:0]                        dropped_count_o
);
    localparam int CntW = $clog2(MaxInFlight + 1);
    localparam int TmoW = $clog2(TimeoutCycles + 1);

    typedef enum logic [1:0] {IDLE, WAIT_TICK, ISSUE, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [PeriodWidth-1:0] per_cnt_q, per_cnt_d;
    logic [CntW-1:0]        inflight_q, inflight_d;
    logic [TmoW-1:0]        tmo_q, tmo_d;
    logic [DataWidth-1:0]   hold_q, hold_d;
    logic                   underrun_q, overrun_q, proto_q, timeout_q;

    logic [PeriodWidth-1:0] reload;
    logic tick, full, accept, issue_fire, ret_ok;
    logic underrun_ev, overrun_ev, proto_ev, timeout_ev;

    // A period of 0 behaves like 1, so the reload value never underflows.
    assign reload      = (period_i == '0) ? '0 : period_i - PeriodWidth'(1);
    assign tick        = (per_cnt_q == '0) &&
                         ((state_q == ISSUE) || ((state_q == WAIT_TICK) && enable_i));
    assign full        = (inflight_q == CntW'(MaxInFlight));
    assign accept      = tick && (state_q == WAIT_TICK) && src_valid_i && !full;
    assign underrun_ev = tick && (state_q == WAIT_TICK) && !src_valid_i;
    assign overrun_ev  = tick && ((state_q == ISSUE) ||
                                  ((state_q == WAIT_TICK) && src_valid_i && full));
    assign issue_fire  = (state_q == ISSUE) && chain_ready_i;
    assign ret_ok      = ret_fire_i && (inflight_q != '0);
    assign proto_ev    = ret_fire_i && (inflight_q == '0);

    always_comb begin
        inflight_d = inflight_q;
        tmo_d      = tmo_q;
        timeout_ev = 1'b0;
        if (issue_fire && !ret_ok) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!issue_fire && ret_ok) begin
            inflight_d = inflight_q - 1'b1;
        end
        // Stall watchdog: a timeout flushes the in-flight count so DRAIN can finish.
        if ((inflight_q == '0) || ret_fire_i) begin
            tmo_d = '0;
        end else if (tmo_q == TmoW'(TimeoutCycles - 1)) begin
            tmo_d      = '0;
            timeout_ev = 1'b1;
            inflight_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        hold_d    = accept ? src_data_i : hold_q;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d   = WAIT_TICK;
                    per_cnt_d = reload;
                end
            end
            WAIT_TICK: begin
                if (!enable_i) begin
                    state_d = (inflight_d != '0) ? DRAIN : IDLE;
                end else begin
                    per_cnt_d = tick ? reload : per_cnt_q - PeriodWidth'(1);
                    if (accept) state_d = ISSUE;
                end
            end
            ISSUE: begin
                per_cnt_d = tick ? reload : per_cnt_q - PeriodWidth'(1);
                if (issue_fire) state_d = enable_i ? WAIT_TICK : DRAIN;
            end
            default: begin
                if (inflight_d == '0) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            per_cnt_q  <= '0;
            inflight_q <= '0;
            tmo_q      <= '0;
            hold_q     <= '0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
            proto_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            per_cnt_q  <= per_cnt_d;
            inflight_q <= inflight_d;
            tmo_q      <= tmo_d;
            hold_q     <= hold_d;
            underrun_q <= (underrun_q && !clear_i) || underrun_ev;
            overrun_q  <= (overrun_q  && !clear_i) || overrun_ev;
            proto_q    <= (proto_q    && !clear_i) || proto_ev;
            timeout_q  <= (timeout_q  && !clear_i) || timeout_ev;
        end
    end

    assign src_ready_o   = accept;
    assign sample_tick_o = tick;
    assign chain_valid_o = (state_q == ISSUE);
    assign chain_data_o  = hold_q;
    assign inflight_o    = inflight_q;
    assign busy_o        = (state_q != IDLE);
    assign underrun_o    = underrun_q;
    assign overrun_o     = overrun_q;
    assign proto_err_o   = proto_q;
    assign timeout_o     = timeout_q;

`ifdef AU_SEQ_STATS_EN
    logic [31:0] issued_q;
    logic [15:0] dropped_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            issued_q  <= '0;
            dropped_q <= '0;
        end else begin
            if (issue_fire) issued_q <= issued_q + 1'b1;
            if ((underrun_ev || overrun_ev) && (dropped_q != 16'hFFFF)) begin
                dropped_q <= dropped_q + 1'b1;
            end
        end
    end

    assign issued_count_o  = issued_q;
    assign dropped_count_o = dropped_q;
`else
    assign issued_count_o  = '0;
    assign dropped_count_o = '0;
`endif
endmodule
